// File: rtl/m_div_unit_pkg.sv
// Shared definitions for the M-extension divider: ALU operation codes,
// funct3 codes, FSM state encodings and small decode helpers.
package m_div_unit_pkg;

  localparam int XLEN = 32;

  // ALU control operation codes accepted by the divider
  localparam logic [4:0] ALU_DIV  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REM  = 5'd18;
  localparam logic [4:0] ALU_REMU = 5'd19;

  // funct3 encodings of the RV32M divide instructions
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Number of restoring iterations; the counter reaching this value means
  // the quotient is complete and the sign fixup cycle is running.
  localparam logic [5:0] M_DIV_ITERS = 6'd32;

  typedef enum logic [1:0] {
    M_DIV_IDLE = 2'd0,
    M_DIV_CALC = 2'd1,
    M_DIV_DONE = 2'd2
  } m_div_state_t;

  function automatic logic is_div_code(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  function automatic logic is_signed_code(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

  function automatic logic is_rem_code(input logic [4:0] code);
    return (code == ALU_REM) || (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/m_div_unit_div_sign_fix.sv
// Two's complement conditional negate: produces |x| from a signed operand
// and restores the sign of an unsigned quotient/remainder.
module div_sign_fix
  import m_div_unit_pkg::*;
(
  input  logic [XLEN-1:0] value,
  input  logic            negate,
  output logic [XLEN-1:0] fixed
);

  assign fixed = negate ? (~value + 32'd1) : value;

endmodule

// File: rtl/m_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle, then a sign fixup cycle into DONE.
// Divide-by-zero and signed overflow skip the iterations entirely.
module m_div_unit
  import m_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      ALU_selection,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  m_div_state_t    state_reg, state_next;
  logic [5:0]      cnt_reg;
  logic [XLEN-1:0] divisor_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic            is_rem_reg, neg_q_reg, neg_r_reg, div_zero_reg, ovf_reg;
  logic [XLEN-1:0] result_reg;

  logic            in_signed, accept, special, last_iter;
  logic [XLEN-1:0] abs_a, abs_b, q_fixed, r_fixed, final_result;
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] rem_next;

  assign in_signed = is_signed_code(ALU_selection);
  assign accept    = (state_reg == M_DIV_IDLE) && start && !kill &&
                     is_div_code(ALU_selection);
  assign special   = div_zero_reg || ovf_reg;
  assign last_iter = (cnt_reg == M_DIV_ITERS);

  div_sign_fix u_abs_a (.value(op_a),           .negate(in_signed && op_a[31]), .fixed(abs_a));
  div_sign_fix u_abs_b (.value(op_b),           .negate(in_signed && op_b[31]), .fixed(abs_b));
  div_sign_fix u_fix_q (.value(quo_reg),        .negate(neg_q_reg),             .fixed(q_fixed));
  div_sign_fix u_fix_r (.value(rem_reg),        .negate(neg_r_reg),             .fixed(r_fixed));

  // 33-bit partial remainder: previous remainder shifted left with the next
  // dividend bit; it is only ever below 2*divisor so it never overflows.
  assign shifted  = {rem_reg, quo_reg[31]};
  assign fits     = (shifted >= {1'b0, divisor_reg});
  assign rem_next = fits ? 32'(shifted - {1'b0, divisor_reg}) : shifted[31:0];

  // Pick the architectural result, including the two short-circuit cases.
  // For divide-by-zero rem_reg holds |op_a|, so r_fixed restores op_a exactly.
  always_comb begin
    final_result = is_rem_reg ? r_fixed : q_fixed;
    if (div_zero_reg) begin
      final_result = is_rem_reg ? r_fixed : 32'hFFFF_FFFF;
    end else if (ovf_reg) begin
      final_result = is_rem_reg ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= M_DIV_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; kill wins over everything once an op is in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      M_DIV_IDLE: if (accept) state_next = M_DIV_CALC;
      M_DIV_CALC: begin
        if (kill)                                  state_next = M_DIV_IDLE;
        else if ((special && cnt_reg == 6'd0) || last_iter) state_next = M_DIV_DONE;
      end
      M_DIV_DONE: state_next = M_DIV_IDLE;
      default:    state_next = M_DIV_IDLE;
    endcase
  end

  // Operand latch, restoring iteration and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= 6'd0;
      divisor_reg  <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      is_rem_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      result_reg   <= '0;
    end else if (accept) begin
      cnt_reg      <= 6'd0;
      divisor_reg  <= abs_b;
      quo_reg      <= abs_a;
      rem_reg      <= (op_b == '0) ? abs_a : '0;
      is_rem_reg   <= is_rem_code(ALU_selection);
      neg_q_reg    <= in_signed && (op_a[31] ^ op_b[31]);
      neg_r_reg    <= in_signed && op_a[31];
      div_zero_reg <= (op_b == '0);
      ovf_reg      <= in_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    end else if (state_reg == M_DIV_CALC && !kill) begin
      if ((special && cnt_reg == 6'd0) || last_iter) begin
        result_reg <= final_result;
      end else begin
        rem_reg <= rem_next;
        quo_reg <= {quo_reg[30:0], fits};
        cnt_reg <= cnt_reg + 6'd1;
      end
    end
  end

  assign busy   = (state_reg != M_DIV_IDLE);
  assign done   = (state_reg == M_DIV_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_m_div_unit.sv
// Scoreboard bench for m_div_unit: stimulus pushes expected result and done
// edge, a negedge monitor pops and compares on every done pulse.
module tb_m_div_unit;
  import m_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [4:0]  alu_sel = 5'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int          edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_res = 32'd0;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          edge_at;
  } exp_t;

  exp_t sb[$];

  m_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_selection(alu_sel),
    .op_a(op_a), .op_b(op_b), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at edge %0d expected none", edge_cnt);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_edge"}, 32'(edge_cnt), 32'(e.edge_at));
        last_res = e.res;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  // Issue one request; when push is set, queue the result expected `lat`
  // edges after the accepting edge.
  task automatic issue(input string name, input logic [4:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want, input int lat,
                       input bit push);
    exp_t e;
    wait_idle();
    alu_sel = sel;
    op_a    = a;
    op_b    = b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.name    = name;
      e.res     = want;
      e.edge_at = edge_cnt + lat;
      sb.push_back(e);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'd0);

    // Release and start in the same cycle: must be accepted on the first edge.
    rst_n = 1'b1;
    issue("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
    check("first_edge_accept", {31'd0, busy}, 32'd1);

    issue("remu_100_7",  ALU_REMU, 32'd100,        32'd7,          32'd2,          33, 1);
    issue("div_m7_2",    ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 1);
    issue("rem_m7_2",    ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 1);
    issue("div_7_m2",    ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, 1);
    issue("rem_7_m2",    ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, 1);
    issue("div_5_0",     ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1);
    issue("remu_5_0",    ALU_REMU, 32'd5,          32'd0,          32'd5,          1,  1);
    issue("divu_0_0",    ALU_DIVU, 32'd0,          32'd0,          32'hFFFF_FFFF,  1,  1);
    issue("rem_m7_0",    ALU_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1,  1);
    issue("div_ovf",     ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1);
    issue("rem_ovf",     ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1);
    issue("divu_big_m1", ALU_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 1);
    issue("divu_max_1",  ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33, 1);
    issue("remu_max_16", ALU_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         33, 1);
    issue("div_min_3",   ALU_DIV,  32'h8000_0000,  32'd3,          32'hD555_5556,  33, 1);
    issue("rem_min_3",   ALU_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  33, 1);

    // Unsupported operation code is ignored.
    wait_idle();
    alu_sel = 5'd3;
    op_a    = 32'd10;
    op_b    = 32'd2;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("bad_code_ignored", {31'd0, busy}, 32'd0);

    // Second start mid-operation is ignored; first result still correct.
    issue("divu_100_7_b", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
    repeat (9) @(posedge clk);
    #1;
    alu_sel = ALU_DIV;
    op_a    = 32'd5;
    op_b    = 32'd0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_still_busy", {31'd0, busy}, 32'd1);

    // Kill after edge 20: idle at edge 21, no done, result unchanged.
    issue("kill_op", ALU_DIVU, 32'd1000, 32'd10, 32'd0, 33, 0);
    repeat (20) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_idle",   {31'd0, busy}, 32'd0);
    check("kill_result", result,        last_res);
    repeat (40) @(negedge clk);

    // Start held during the done cycle: ignored there, accepted one cycle later.
    issue("divu_50_5", ALU_DIVU, 32'd50, 32'd5, 32'd10, 33, 1);
    begin
      exp_t e;
      int   i;
      for (i = 0; i < 60 && !done; i++) @(negedge clk);
      if (!done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_wait: got no done expected done within 60 cycles");
      end
      alu_sel = ALU_DIVU;
      op_a    = 32'd81;
      op_b    = 32'd9;
      start   = 1'b1;
      @(posedge clk);
      #1;
      check("start_at_done_ignored", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      start     = 1'b0;
      e.name    = "divu_81_9";
      e.res     = 32'd9;
      e.edge_at = edge_cnt + 33;
      sb.push_back(e);
    end

    // Asynchronous reset mid-CALC clears everything at once.
    issue("reset_op", ALU_DIVU, 32'd1000, 32'd10, 32'd0, 33, 0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'd0, busy}, 32'd0);
    check("async_rst_done",   {31'd0, done}, 32'd0);
    check("async_rst_result", result,        32'd0);
    last_res = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    issue("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 33, 1);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
